// File: rtl/nock_mem_pkg.sv
// Shared constants for the Nock memory traversal unit: cell layout, tag bits, memory/error/return codes, FSM states.
// Latency: n/a; backpressure: n/a.
package nock_mem_pkg;

    localparam int ADDR_W_DFLT = 10;
    localparam int DATA_W_DFLT = 64;
    localparam int TAG_W_DFLT  = 4;

    localparam int TAG_HI  = 63;
    localparam int TAG_LO  = 60;
    localparam int HEAD_HI = 59;
    localparam int HEAD_LO = 30;
    localparam int TAIL_HI = 29;
    localparam int TAIL_LO = 0;

    localparam int TAG_EXEC      = 3;
    localparam int TAG_HEAD_ATOM = 1;
    localparam int TAG_TAIL_ATOM = 0;

    localparam logic [1:0] MEM_READ  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_ALLOC = 2'b10;
    localparam logic [1:0] MEM_FREE  = 2'b11;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_STACK_OVF  = 8'h01;
    localparam logic [7:0] ERR_NULL_PTR   = 8'h02;
    localparam logic [7:0] ERR_EXEC_FAULT = 8'h03;
    localparam logic [7:0] ERR_BAD_RETURN = 8'h04;

    localparam logic [3:0] RET_REFETCH = 4'd0;
    localparam logic [3:0] RET_POP     = 4'd1;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_WAIT0, S_WAIT, S_DECIDE,
        S_EXEC, S_EXEC_WAIT, S_POP, S_DONE, S_ERR
    } state_t;

endpackage

// File: rtl/nock_traversal_unit_if.sv
// Memory port and execute hand-off bundle between the traversal unit and its environment.
// Latency: wires only; backpressure: mem_ready from memory, execute_finished from execute.
interface nock_traversal_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 4
);
    logic              mem_ready;
    logic [DATA_W-1:0] read_data;
    logic [ADDR_W-1:0] free_addr;
    logic [ADDR_W-1:0] address;
    logic              mem_execute;
    logic [1:0]        mem_func;
    logic [DATA_W-1:0] write_data;
    logic              mux_controller;
    logic [ADDR_W-1:0] execute_address;
    logic [TAG_W-1:0]  execute_tag;
    logic [DATA_W-1:0] execute_data;
    logic              execute_finished;
    logic [3:0]        execute_return_sys_func;
    logic [3:0]        execute_return_state;

    modport master (
        input  mem_ready, read_data, free_addr,
               execute_finished, execute_return_sys_func, execute_return_state,
        output address, mem_execute, mem_func, write_data,
               mux_controller, execute_address, execute_tag, execute_data
    );

    modport slave (
        output mem_ready, read_data, free_addr,
               execute_finished, execute_return_sys_func, execute_return_state,
        input  address, mem_execute, mem_func, write_data,
               mux_controller, execute_address, execute_tag, execute_data
    );
endinterface

// File: rtl/traversal_stack.sv
// LIFO of pending tail pointers; top is a combinational read of the newest entry.
// Latency: push/pop take effect next cycle; backpressure: full/empty flags, caller must not overrun.
module traversal_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign top   = mem[IW'(count - CW'(1))];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem[count[IW-1:0]] <= din;
        end
    end
endmodule

// File: rtl/nock_traversal_unit.sv
// Depth-first head-first walk of a Nock noun in memory, handing execute-tagged cells to the execute module.
// Latency: >=4 cycles per cell fetch; backpressure: stalls on mem_ready, execute_finished and power=0.
module nock_traversal_unit
    import nock_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DFLT,
    parameter int DATA_W      = DATA_W_DFLT,
    parameter int TAG_W       = TAG_W_DFLT,
    parameter int STACK_DEPTH = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              power,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              execute,
    output logic              finished,
    output logic [7:0]        error,
    nock_traversal_unit_if.master bus
);
    state_t            state, state_next;
    logic [ADDR_W-1:0] cur, cur_next;
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] head_addr, tail_addr, st_top;
    logic              head_ptr, tail_ptr;
    logic              st_push, st_pop, st_clear, st_empty, st_full;
    logic              issue_req, latch_word, start_exec, end_exec, set_err, set_done, leave;
    logic [7:0]        err_code;
    logic              unused_bits;

    assign head_addr = word[HEAD_LO +: ADDR_W];
    assign tail_addr = word[TAIL_LO +: ADDR_W];
    assign head_ptr  = !word[TAG_LO + TAG_HEAD_ATOM];
    assign tail_ptr  = !word[TAG_LO + TAG_TAIL_ATOM];
    assign unused_bits = ^{bus.free_addr, word[HEAD_HI:HEAD_LO+ADDR_W], word[TAIL_HI:TAIL_LO+ADDR_W]};

    assign bus.mem_func   = MEM_READ;
    assign bus.write_data = '0;

    traversal_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk(clk), .rst(rst), .clear(st_clear), .push(st_push), .pop(st_pop),
        .din(tail_addr), .top(st_top), .empty(st_empty), .full(st_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        cur_next   = cur;
        issue_req  = 1'b0;
        latch_word = 1'b0;
        st_push    = 1'b0;
        st_pop     = 1'b0;
        st_clear   = 1'b0;
        start_exec = 1'b0;
        end_exec   = 1'b0;
        set_err    = 1'b0;
        set_done   = 1'b0;
        leave      = 1'b0;
        err_code   = ERR_NONE;
        if (power) begin
            case (state)
                S_IDLE: if (execute && bus.mem_ready) begin
                    cur_next = start_addr; st_clear = 1'b1; state_next = S_REQ;
                end
                S_REQ: if (cur == '0) begin
                    set_err = 1'b1; err_code = ERR_NULL_PTR; state_next = S_ERR;
                end else if (bus.mem_ready) begin
                    issue_req = 1'b1; state_next = S_WAIT0;
                end
                // Memory may still report ready on the cycle right after the strobe.
                S_WAIT0: state_next = S_WAIT;
                S_WAIT: if (bus.mem_ready) begin
                    latch_word = 1'b1; state_next = S_DECIDE;
                end
                S_DECIDE: if (word[TAG_LO + TAG_EXEC]) begin
                    state_next = S_EXEC;
                end else if (head_ptr) begin
                    if (tail_ptr && st_full) begin
                        set_err = 1'b1; err_code = ERR_STACK_OVF; state_next = S_ERR;
                    end else begin
                        st_push = tail_ptr; cur_next = head_addr; state_next = S_REQ;
                    end
                end else if (tail_ptr) begin
                    cur_next = tail_addr; state_next = S_REQ;
                end else begin
                    state_next = S_POP;
                end
                S_EXEC: begin
                    start_exec = 1'b1; state_next = S_EXEC_WAIT;
                end
                S_EXEC_WAIT: if (bus.execute_finished) begin
                    end_exec = 1'b1;
                    if (bus.execute_return_sys_func != 4'd0) begin
                        set_err = 1'b1; err_code = ERR_EXEC_FAULT; state_next = S_ERR;
                    end else begin
                        case (bus.execute_return_state)
                            RET_REFETCH: state_next = S_REQ;
                            RET_POP:     state_next = S_POP;
                            default: begin
                                set_err = 1'b1; err_code = ERR_BAD_RETURN; state_next = S_ERR;
                            end
                        endcase
                    end
                end
                S_POP: if (st_empty) begin
                    set_done = 1'b1; state_next = S_DONE;
                end else begin
                    cur_next = st_top; st_pop = 1'b1; state_next = S_REQ;
                end
                S_DONE, S_ERR: if (!execute) begin
                    leave = 1'b1; state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur                 <= '0;
            word                <= '0;
            finished            <= 1'b0;
            error               <= ERR_NONE;
            bus.address         <= '0;
            bus.mem_execute     <= 1'b0;
            bus.mux_controller  <= 1'b0;
            bus.execute_address <= '0;
            bus.execute_tag     <= '0;
            bus.execute_data    <= '0;
        end else begin
            cur             <= cur_next;
            bus.mem_execute <= issue_req;
            if (issue_req)  bus.address <= cur;
            if (latch_word) word <= bus.read_data;
            if (start_exec) begin
                bus.mux_controller  <= 1'b1;
                bus.execute_address <= cur;
                bus.execute_tag     <= word[TAG_HI:TAG_LO];
                bus.execute_data    <= word;
            end
            if (end_exec) bus.mux_controller <= 1'b0;
            if (set_err) begin
                error    <= err_code;
                finished <= 1'b1;
            end
            if (set_done) finished <= 1'b1;
            if (leave) begin
                finished <= 1'b0;
                error    <= ERR_NONE;
            end
        end
    end
endmodule

// File: tb/tb_nock_traversal_unit.sv
// Directed and randomized walks checked against a queue-based traversal model of the noun.
module tb_nock_traversal_unit;
    import nock_mem_pkg::*;

    logic       clk = 1'b0;
    logic       rst, power, execute;
    logic [9:0] start_addr;
    logic       finished;
    logic [7:0] error;

    nock_traversal_unit_if bus();

    nock_traversal_unit dut (
        .clk(clk), .rst(rst), .power(power), .start_addr(start_addr),
        .execute(execute), .finished(finished), .error(error), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [1024];
    logic [63:0] mm  [1024];
    logic [9:0]  obs_reads[$];
    int          overlap_cnt = 0;
    logic [9:0]  exp_reads[$], exp_exec_addr[$], obs_exec_addr[$];
    logic [3:0]  exp_exec_tag[$], obs_exec_tag[$];
    int          exp_err;
    logic [3:0]  resp_st [16];
    logic [3:0]  resp_sy [16];
    int          exec_k, read_base;
    bit          hold_exec = 1'b0;
    int          n_cmp = 0, n_err = 0;

    // Memory: answers each strobe after 0..3 not-ready cycles.
    initial begin : mem_model
        int d;
        bus.mem_ready = 1'b1;
        bus.read_data = '0;
        bus.free_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_execute === 1'b1) begin
                if (bus.mux_controller === 1'b1) overlap_cnt++;
                obs_reads.push_back(bus.address);
                d = $urandom_range(0, 3);
                if (d > 0) begin
                    bus.mem_ready = 1'b0;
                    repeat (d) @(posedge clk);
                    #1;
                end
                bus.read_data = mem[bus.address];
                bus.mem_ready = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] t, input logic [29:0] h, input logic [29:0] tl);
        return {t, h, tl};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic fill_resp(input logic [3:0] st0, input logic [3:0] sy0);
        for (int i = 0; i < 16; i++) begin resp_st[i] = 4'd1; resp_sy[i] = 4'd0; end
        resp_st[0] = st0;
        resp_sy[0] = sy0;
    endtask

    // Reference walk: explicit pending-tail stack, head before tail.
    function automatic void model_run(input logic [9:0] root);
        logic [9:0]  stk[$];
        logic [9:0]  cur = root;
        logic [63:0] w;
        int          k = 0;
        exp_reads.delete(); exp_exec_addr.delete(); exp_exec_tag.delete();
        exp_err = 0;
        for (int g = 0; g < 20000; g++) begin
            if (cur == 10'd0) begin exp_err = 2; return; end
            exp_reads.push_back(cur);
            w = mm[cur];
            if (w[63]) begin
                exp_exec_addr.push_back(cur);
                exp_exec_tag.push_back(w[63:60]);
                if (resp_sy[k % 16] != 4'd0) begin exp_err = 3; return; end
                if (resp_st[k % 16] == 4'd0) begin mm[cur][63] = 1'b0; k++; continue; end
                if (resp_st[k % 16] != 4'd1) begin exp_err = 4; return; end
                k++;
            end else if (!w[61]) begin
                if (!w[60]) begin
                    if (stk.size() >= 32) begin exp_err = 1; return; end
                    stk.push_back(w[9:0]);
                end
                cur = w[39:30];
                continue;
            end else if (!w[60]) begin
                cur = w[9:0];
                continue;
            end
            if (stk.size() == 0) return;
            cur = stk.pop_back();
        end
    endfunction

    task automatic start_run(input logic [9:0] root);
        mm = mem;
        model_run(root);
        read_base = obs_reads.size();
        obs_exec_addr.delete(); obs_exec_tag.delete();
        exec_k = 0;
        start_addr = root;
        execute = 1'b1;
    endtask

    task automatic serve_exec(input string name);
        logic [9:0]  a   = bus.execute_address;
        logic [63:0] dat = bus.execute_data;
        logic [3:0]  st  = resp_st[exec_k % 16];
        logic [3:0]  sy  = resp_sy[exec_k % 16];
        obs_exec_addr.push_back(a);
        obs_exec_tag.push_back(bus.execute_tag);
        exec_k++;
        check({name, " exec_data"}, dat, mem[a]);
        if (st == 4'd0 && sy == 4'd0) mem[a][63] = 1'b0;
        repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #3;
            check({name, " exec_hold"}, 64'({bus.mux_controller, bus.mem_execute, bus.execute_address}), 64'({1'b1, 1'b0, a}));
        end
        bus.execute_return_state    = st;
        bus.execute_return_sys_func = sy;
        bus.execute_finished        = 1'b1;
        @(posedge clk); #1;
        bus.execute_finished = 1'b0;
        check({name, " release"}, 64'(bus.mux_controller), 64'd0);
    endtask

    task automatic finish_run(input string name);
        int cyc = 0;
        int nobs;
        while (finished !== 1'b1 && cyc < 4000) begin
            @(posedge clk); #3;
            cyc++;
            if (bus.mux_controller === 1'b1 && !hold_exec) serve_exec(name);
        end
        check({name, " finished"}, 64'(finished), 64'd1);
        check({name, " error"}, 64'(error), 64'(exp_err));
        nobs = obs_reads.size() - read_base;
        check({name, " nreads"}, 64'(nobs), 64'(exp_reads.size()));
        for (int i = 0; i < exp_reads.size() && i < nobs; i++)
            check($sformatf("%s read%0d", name, i), 64'(obs_reads[read_base + i]), 64'(exp_reads[i]));
        check({name, " nexec"}, 64'(obs_exec_addr.size()), 64'(exp_exec_addr.size()));
        for (int i = 0; i < exp_exec_addr.size() && i < obs_exec_addr.size(); i++) begin
            check($sformatf("%s exec_addr%0d", name, i), 64'(obs_exec_addr[i]), 64'(exp_exec_addr[i]));
            check($sformatf("%s exec_tag%0d", name, i), 64'(obs_exec_tag[i]), 64'(exp_exec_tag[i]));
        end
        execute = 1'b0;
        @(posedge clk); #3;
        check({name, " idle_clear"}, 64'({finished, error}), 64'd0);
    endtask

    task automatic gen_random();
        int off  = $urandom_range(1, 990);
        int n    = $urandom_range(1, 24);
        int next = 1;
        logic [29:0] hf, tf;
        logic        ha, ta, ex;
        clear_mem();
        for (int j = 0; j < next; j++) begin
            ex = ($urandom_range(0, 5) == 0);
            ha = 1'b1; hf = 30'($urandom);
            ta = 1'b1; tf = 30'($urandom);
            if (next < n && $urandom_range(0, 1) == 1) begin
                ha = 1'b0; hf = {20'($urandom), 10'(off + next)}; next++;
            end
            if (next < n && $urandom_range(0, 1) == 1) begin
                ta = 1'b0; tf = {20'($urandom), 10'(off + next)}; next++;
            end
            mem[off + j] = mk({ex, 1'($urandom), ha, ta}, hf, tf);
        end
        for (int i = 0; i < 16; i++) begin
            int r = $urandom_range(0, 9);
            resp_st[i] = (r < 5) ? 4'd1 : (r < 9) ? 4'd0 : 4'($urandom_range(2, 15));
            resp_sy[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        end
        start_run(10'(off));
    endtask

    initial begin
        int cyc, n;
        logic [9:0] a;
        rst = 1'b0; power = 1'b1; execute = 1'b0; start_addr = '0;
        bus.execute_finished = 1'b0;
        bus.execute_return_state = '0;
        bus.execute_return_sys_func = '0;
        clear_mem();
        fill_resp(4'd1, 4'd0);
        repeat (3) @(posedge clk);
        #3;
        check("reset_outputs", 64'({finished, error, bus.mux_controller, bus.mem_execute, bus.address, bus.mem_func}), 64'd0);
        check("reset_write_data", bus.write_data, 64'd0);
        rst = 1'b1;
        @(posedge clk); #3;

        mem[1] = mk(4'b0011, 30'd5, 30'd7);
        start_run(10'd1); finish_run("single");

        clear_mem();
        mem[1] = mk(4'b0000, 30'd2, 30'd3);
        mem[2] = mk(4'b0011, 30'd10, 30'd10);
        mem[3] = mk(4'b0011, 30'd10, 30'd10);
        start_run(10'd1); finish_run("tree3");

        mem[2] = mk(4'b1011, 30'd10, 30'd10);
        fill_resp(4'd1, 4'd0); start_run(10'd1); finish_run("exec_pop");
        mem[2] = mk(4'b1011, 30'd10, 30'd10);
        fill_resp(4'd0, 4'd0); start_run(10'd1); finish_run("exec_refetch");
        mem[2] = mk(4'b1011, 30'd10, 30'd10);
        fill_resp(4'd1, 4'd5); start_run(10'd1); finish_run("exec_fault");
        mem[2] = mk(4'b1011, 30'd10, 30'd10);
        fill_resp(4'd2, 4'd0); start_run(10'd1); finish_run("exec_bad_ret");

        clear_mem();
        for (int i = 1; i <= 33; i++) mem[i] = mk(4'b0000, 30'(i + 1), 30'(200 + i));
        start_run(10'd1); finish_run("overflow");

        clear_mem();
        mem[1] = mk(4'b0001, 30'd0, 30'd9);
        start_run(10'd1); finish_run("null_head");

        clear_mem();
        mem[1] = mk(4'b0000, 30'd2, 30'd3);
        mem[2] = mk(4'b0000, 30'd4, 30'd5);
        for (int i = 3; i <= 5; i++) mem[i] = mk(4'b0011, 30'd1, 30'd1);
        start_run(10'd1);
        cyc = 0;
        while (obs_reads.size() - read_base < 2 && cyc < 200) begin @(posedge clk); #3; cyc++; end
        power = 1'b0;
        n = obs_reads.size();
        a = bus.address;
        repeat (8) @(posedge clk);
        #3;
        check("freeze_reads", 64'(obs_reads.size()), 64'(n));
        check("freeze_hold", 64'({bus.address, finished, bus.mem_execute}), 64'({a, 1'b0, 1'b0}));
        power = 1'b1;
        finish_run("freeze");

        clear_mem();
        mem[1] = mk(4'b0000, 30'd2, 30'd3);
        mem[2] = mk(4'b1011, 30'd10, 30'd10);
        mem[3] = mk(4'b0011, 30'd10, 30'd10);
        hold_exec = 1'b1;
        start_run(10'd1);
        cyc = 0;
        while (bus.mux_controller !== 1'b1 && cyc < 200) begin @(posedge clk); #3; cyc++; end
        check("rst_reached_exec", 64'(bus.mux_controller), 64'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_outputs", 64'({bus.mux_controller, finished, error, bus.mem_execute}), 64'd0);
        check("rst_state", 64'(dut.state), 64'(S_IDLE));
        execute = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        hold_exec = 1'b0;
        @(posedge clk); #3;
        check("rst_after", 64'({finished, bus.mux_controller}), 64'd0);

        for (int t = 0; t < 25; t++) begin
            gen_random();
            finish_run($sformatf("rand%0d", t));
        end

        check("no_req_while_exec", 64'(overlap_cnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
